// File: rtl/asic_output_classifier.sv
// rtl/asic_output_classifier.sv - XADC DRP poller, box-car averager and argmax classifier
// Reads NUM_CH aux channels per EOS, averages 2^AVG_LOG2 rounds, then picks the strongest output.
module asic_output_classifier #(
  parameter int         NUM_CH    = 4,
  parameter logic [6:0] BASE_ADDR = 7'h10,
  parameter int         DATA_W    = 12,
  parameter int         AVG_LOG2  = 2,
  parameter int         TIMEOUT   = 63,
  localparam int        IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [DATA_W-1:0]        threshold,
  output logic [6:0]               DADDR,
  output logic                     DEN,
  output logic [15:0]              DI,
  output logic                     DWE,
  input  logic                     BUSY,
  input  logic [15:0]              DO,
  input  logic                     DRDY,
  input  logic                     EOS,
  output logic [NUM_CH*DATA_W-1:0] measured,
  output logic [IDX_W-1:0]         network_output,
  output logic                     no_decision,
  output logic                     result_valid,
  output logic                     drp_timeout
);

  localparam int ACC_W    = DATA_W + AVG_LOG2;
  localparam int RND_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LAST_RND = (1 << AVG_LOG2) - 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, AVG, CMP, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ch_q, ch_d;
  logic [RND_W-1:0]  rnd_q, rnd_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [DATA_W-1:0] meas_q [NUM_CH];
  logic [DATA_W-1:0] meas_d [NUM_CH];
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [DATA_W-1:0] best_val_q, best_val_d;
  logic [IDX_W-1:0]  net_q, net_d;
  logic              nodec_q, nodec_d;
  logic              tmo_flag_q, tmo_flag_d;
  logic [IDX_W-1:0]  cand_idx;
  logic [DATA_W-1:0] cand_val;
  logic              unused_inputs;

  // BUSY never gates a read, and only the top DATA_W bits of DO carry the measurement.
  assign unused_inputs = ^{BUSY, DO};

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    rnd_d        = rnd_q;
    tmo_cnt_d    = tmo_cnt_q;
    acc_d        = acc_q;
    meas_d       = meas_q;
    best_idx_d   = best_idx_q;
    best_val_d   = best_val_q;
    net_d        = net_q;
    nodec_d      = nodec_q;
    tmo_flag_d   = tmo_flag_q;
    cand_idx     = best_idx_q;
    cand_val     = best_val_q;
    DEN          = 1'b0;
    DADDR        = 7'd0;
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (EOS && enable) begin
          ch_d    = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        DEN       = 1'b1;
        DADDR     = BASE_ADDR + 7'(ch_q);
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (DRDY) begin
          acc_d[ch_q] = acc_q[ch_q] + ACC_W'(DO[15 -: DATA_W]);
          if (ch_q != IDX_W'(NUM_CH - 1)) begin
            ch_d    = ch_q + 1'b1;
            state_d = REQ;
          end else if (int'(rnd_q) < LAST_RND) begin
            rnd_d   = rnd_q + 1'b1;
            state_d = IDLE;
          end else begin
            state_d = AVG;
          end
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          // A partial round is useless for averaging, so it is discarded entirely.
          tmo_flag_d = 1'b1;
          rnd_d      = '0;
          for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
          state_d    = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      AVG: begin
        for (int c = 0; c < NUM_CH; c++) begin
          meas_d[c] = DATA_W'(acc_q[c] >> AVG_LOG2);
          acc_d[c]  = '0;
        end
        rnd_d   = '0;
        ch_d    = '0;
        state_d = CMP;
      end
      CMP: begin
        if ((ch_q == '0) || (meas_q[ch_q] > best_val_q)) begin
          cand_idx = ch_q;
          cand_val = meas_q[ch_q];
        end
        best_idx_d = cand_idx;
        best_val_d = cand_val;
        // Decision is registered on the final scan step so it is visible alongside result_valid.
        if (ch_q == IDX_W'(NUM_CH - 1)) begin
          net_d   = cand_idx;
          nodec_d = (cand_val < threshold);
          state_d = DONE;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        tmo_flag_d   = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      rnd_q      <= '0;
      tmo_cnt_q  <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      net_q      <= '0;
      nodec_q    <= 1'b0;
      tmo_flag_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c]  <= '0;
        meas_q[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      rnd_q      <= rnd_d;
      tmo_cnt_q  <= tmo_cnt_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      net_q      <= net_d;
      nodec_q    <= nodec_d;
      tmo_flag_q <= tmo_flag_d;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c]  <= acc_d[c];
        meas_q[c] <= meas_d[c];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_meas
    assign measured[g*DATA_W +: DATA_W] = meas_q[g];
  end

  assign network_output = net_q;
  assign no_decision    = nodec_q;
  assign drp_timeout    = tmo_flag_q;
  assign DI             = 16'd0;
  assign DWE            = 1'b0;

endmodule

// File: tb/tb_asic_output_classifier.sv
// tb/tb_asic_output_classifier.sv - self-checking bench for asic_output_classifier
// Randomised DRP responder plus an arithmetic reference model of averaging and argmax.
module tb_asic_output_classifier;

  logic        clk = 1'b0;
  logic        rst, enable, EOS, DRDY, BUSY;
  logic [11:0] threshold;
  logic [6:0]  DADDR;
  logic        DEN, DWE;
  logic [15:0] DI, DO;
  logic [47:0] measured;
  logic [1:0]  network_output;
  logic        no_decision, result_valid, drp_timeout;

  asic_output_classifier #(
    .NUM_CH(4), .BASE_ADDR(7'h10), .DATA_W(12), .AVG_LOG2(2), .TIMEOUT(63)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .threshold(threshold),
    .DADDR(DADDR), .DEN(DEN), .DI(DI), .DWE(DWE), .BUSY(BUSY),
    .DO(DO), .DRDY(DRDY), .EOS(EOS), .measured(measured),
    .network_output(network_output), .no_decision(no_decision),
    .result_valid(result_valid), .drp_timeout(drp_timeout)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          den_cnt = 0;
  int          rv_count = 0;
  int          rv_cyc = 0;
  int          eos_cyc = 0;
  int          lat = 2;
  int          drop_ch = -1;
  logic [11:0] ch_val [4];
  logic [11:0] set_vals [4][4];
  logic [11:0] exp_meas [4];
  int          exp_net;
  logic        exp_nodec;
  logic [6:0]  addr_log [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (DEN) begin
      den_cnt++;
      addr_log.push_back(DADDR);
    end
    if (result_valid) begin
      rv_count++;
      rv_cyc = cyc;
    end
  end

  initial begin
    BUSY = 1'b0;
    forever begin
      @(posedge clk);
      #1 BUSY = 1'($urandom);
    end
  end

  // DRP responder: answers DEN after `lat` cycles unless the addressed channel is being dropped.
  initial begin
    DRDY = 1'b0;
    DO   = 16'd0;
    forever begin
      @(negedge clk);
      if (DEN && !rst) begin
        automatic int idx = int'(DADDR) - 16;
        if (idx == drop_ch) continue;
        repeat (lat) @(posedge clk);
        #1;
        DRDY = 1'b1;
        DO   = {ch_val[idx], 4'($urandom)};
        @(posedge clk);
        #1 DRDY = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_round(input int r, input bit mid_eos, input bit drop_en);
    for (int c = 0; c < 4; c++) ch_val[c] = set_vals[r][c];
    @(posedge clk);
    #1;
    EOS = 1'b1;
    enable = 1'b1;
    eos_cyc = cyc;
    @(posedge clk);
    #1 EOS = 1'b0;
    if (drop_en) enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (mid_eos) EOS = 1'b1;
    @(posedge clk);
    #1 EOS = 1'b0;
    repeat (36) @(posedge clk);
  endtask

  // Reference: mean of four rounds per channel, first maximum wins, threshold on the winner.
  task automatic model_set();
    for (int c = 0; c < 4; c++) begin
      automatic int sum = 0;
      for (int r = 0; r < 4; r++) sum += int'(set_vals[r][c]);
      exp_meas[c] = 12'(sum / 4);
    end
    exp_net = 0;
    for (int c = 1; c < 4; c++)
      if (exp_meas[c] > exp_meas[exp_net]) exp_net = c;
    exp_nodec = (exp_meas[exp_net] < threshold);
  endtask

  task automatic run_set(input string tag, input bit mid_eos, input bit drop_last_en);
    automatic int den0 = den_cnt;
    automatic int rv0 = rv_count;
    model_set();
    for (int r = 0; r < 4; r++) begin
      run_round(r, mid_eos, drop_last_en && (r == 3));
      if (r == 2) check({tag, "_no_early_rv"}, rv_count - rv0, 0);
    end
    check({tag, "_rv_once"}, rv_count - rv0, 1);
    check({tag, "_den_count"}, den_cnt - den0, 16);
    for (int c = 0; c < 4; c++)
      check($sformatf("%s_meas%0d", tag, c), measured[c*12 +: 12], exp_meas[c]);
    check({tag, "_net"}, network_output, exp_net);
    check({tag, "_nodec"}, no_decision, exp_nodec);
    check({tag, "_latency"}, rv_cyc - eos_cyc, 4 * (1 + lat) + 4 + 2);
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    EOS = 1'b0;
    threshold = 12'h000;
    for (int c = 0; c < 4; c++) ch_val[c] = 12'h000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_den", DEN, 0);
    check("rst_daddr", DADDR, 0);
    check("rst_di_dwe", {DI, DWE}, 0);
    check("rst_measured_lo", measured[31:0], 0);
    check("rst_measured_hi", measured[47:32], 0);
    check("rst_outputs", {network_output, no_decision, result_valid, drp_timeout}, 0);

    // Basic classification with constant readings over the averaging window.
    threshold = 12'h080;
    for (int r = 0; r < 4; r++) begin
      set_vals[r][0] = 12'h100; set_vals[r][1] = 12'h7F0;
      set_vals[r][2] = 12'h300; set_vals[r][3] = 12'h200;
    end
    addr_log.delete();
    run_set("basic", 1'b0, 1'b0);
    check("basic_addr_count", addr_log.size(), 16);
    for (int i = 0; i < 16 && i < addr_log.size(); i++)
      check($sformatf("basic_daddr%0d", i), addr_log[i], 7'h10 + 7'(i % 4));
    check("basic_net_abs", network_output, 1);

    // Averaging across rounds with truncation.
    threshold = 12'(($urandom_range(0, 4095)));
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) set_vals[r][c] = 12'($urandom_range(0, 4095));
      set_vals[r][2] = 12'h400 + 12'(r);
    end
    run_set("avg", 1'b0, 1'b0);
    check("avg_meas2_abs", measured[24 +: 12], 12'h401);

    // Tie below threshold.
    threshold = 12'h060;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) set_vals[r][c] = 12'h050;
    run_set("tie", 1'b0, 1'b0);
    check("tie_net_abs", network_output, 0);
    check("tie_nodec_abs", no_decision, 1);

    // Random sets, the second with a narrow range so ties are frequent.
    for (int it = 0; it < 3; it++) begin
      threshold = (it == 1) ? 12'($urandom_range(0, 4)) : 12'($urandom_range(0, 4095));
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          set_vals[r][c] = (it == 1) ? 12'($urandom_range(0, 3)) : 12'($urandom_range(0, 4095));
      run_set($sformatf("rand%0d", it), 1'b0, 1'b0);
    end

    // EOS with enable low starts nothing.
    begin
      automatic int den0;
      enable = 1'b0;
      @(posedge clk);
      #1 EOS = 1'b1;
      @(posedge clk);
      #1 EOS = 1'b0;
      den0 = den_cnt;
      repeat (20) @(negedge clk);
      check("en_low_no_den", den_cnt - den0, 0);
    end

    // Stray mid-round EOS pulses and enable dropped during the final round.
    threshold = 12'($urandom_range(0, 4095));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) set_vals[r][c] = 12'($urandom_range(0, 4095));
    run_set("eos_en", 1'b1, 1'b1);

    // Timeout on channel 1.
    begin
      automatic bit found = 1'b0;
      automatic int den0, rv0;
      automatic logic [47:0] meas_prev = measured;
      automatic logic [1:0] net_prev = network_output;
      drop_ch = 1;
      ch_val[0] = 12'h123;
      @(posedge clk);
      #1;
      EOS = 1'b1;
      enable = 1'b1;
      @(posedge clk);
      #1 EOS = 1'b0;
      rv0 = rv_count;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (DEN && DADDR == 7'h11) begin
          found = 1'b1;
          break;
        end
      end
      check("tmo_den_ch1_seen", found, 1);
      repeat (63) @(negedge clk);
      check("tmo_not_yet", drp_timeout, 0);
      @(negedge clk);
      check("tmo_flag_set", drp_timeout, 1);
      den0 = den_cnt;
      repeat (10) @(negedge clk);
      check("tmo_idle_no_den", den_cnt - den0, 0);
      check("tmo_no_rv", rv_count - rv0, 0);
      check("tmo_meas_kept", measured, meas_prev);
      check("tmo_net_kept", network_output, net_prev);
      drop_ch = -1;
      threshold = 12'($urandom_range(0, 4095));
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) set_vals[r][c] = 12'($urandom_range(0, 4095));
      run_set("post_tmo", 1'b0, 1'b0);
      check("post_tmo_flag_clear", drp_timeout, 0);
    end

    // Reset during WAIT, then a late DRDY lands in IDLE.
    begin
      automatic int den0, rv0;
      lat = 10;
      for (int c = 0; c < 4; c++) ch_val[c] = 12'hFFF;
      @(posedge clk);
      #1;
      EOS = 1'b1;
      enable = 1'b1;
      @(posedge clk);
      #1 EOS = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      rv0 = rv_count;
      check("mrst_measured", measured, 0);
      check("mrst_outputs", {network_output, no_decision, result_valid, drp_timeout}, 0);
      check("mrst_den", DEN, 0);
      den0 = den_cnt;
      repeat (20) @(negedge clk);
      check("mrst_no_den", den_cnt - den0, 0);
      check("mrst_no_rv", rv_count - rv0, 0);
      lat = 2;
      threshold = 12'($urandom_range(0, 4095));
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) set_vals[r][c] = 12'($urandom_range(0, 4095));
      run_set("post_rst", 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
